// File: rtl/axis_packet_arbiter.sv
// N-to-1 AXI-Stream packet arbiter: round-robin grant, held for a whole packet.
// Optional macro AXIS_PACKET_ARBITER_TDEST_EN adds axis_o_tdest (= current grant).
module axis_packet_arbiter #(
    parameter int AXIS_BYTES        = 1,
    parameter int AXIS_USER_BITS    = 1,
    parameter int NUM_SLAVE_STREAMS = 2,
    localparam int AXIS_DEST_BITS   = (NUM_SLAVE_STREAMS == 1) ? 1 : $clog2(NUM_SLAVE_STREAMS)
) (
    input  logic                                          clk,
    input  logic                                          aresetn,
    input  logic [NUM_SLAVE_STREAMS-1:0]                  axis_i_tvalid,
    output logic [NUM_SLAVE_STREAMS-1:0]                  axis_i_tready,
    input  logic [NUM_SLAVE_STREAMS*AXIS_BYTES*8-1:0]     axis_i_tdata,
    input  logic [NUM_SLAVE_STREAMS*AXIS_USER_BITS-1:0]   axis_i_tuser,
    input  logic [NUM_SLAVE_STREAMS-1:0]                  axis_i_tlast,
    output logic                                          axis_o_tvalid,
    input  logic                                          axis_o_tready,
    output logic [AXIS_BYTES*8-1:0]                       axis_o_tdata,
    output logic [AXIS_USER_BITS-1:0]                     axis_o_tuser,
`ifdef AXIS_PACKET_ARBITER_TDEST_EN
    output logic [AXIS_DEST_BITS-1:0]                     axis_o_tdest,
`endif
    output logic                                          axis_o_tlast
);

    localparam int N  = NUM_SLAVE_STREAMS;
    localparam int DW = AXIS_BYTES * 8;
    localparam int UW = AXIS_USER_BITS;
    localparam int DB = AXIS_DEST_BITS;

    // Handshake: a beat moves on tvalid & tready at the rising edge; the output
    // tvalid never depends on axis_o_tready, only the granted tready mirrors it.

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state, state_nxt;
    logic [DB-1:0]   grant, grant_nxt;
    logic [DB-1:0]   last_grant, last_grant_nxt;
    logic [DB-1:0]   pick;
    logic            found;
    logic            sel_valid;
    logic [DW-1:0]   sel_data;
    logic [UW-1:0]   sel_user;
    logic            sel_last;

    // Round-robin search starting just after last_grant; last_grant is tried last.
    always_comb begin
        pick  = last_grant;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!found && axis_i_tvalid[j] && (j == ((int'(last_grant) + k) % N))) begin
                    found = 1'b1;
                    pick  = DB'(j);
                end
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        sel_user  = '0;
        sel_last  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (int'(grant) == i) begin
                sel_valid = axis_i_tvalid[i];
                sel_data  = axis_i_tdata[i*DW +: DW];
                sel_user  = axis_i_tuser[i*UW +: UW];
                sel_last  = axis_i_tlast[i];
            end
        end
    end

    always_comb begin
        axis_i_tready = '0;
        for (int i = 0; i < N; i++) begin
            axis_i_tready[i] = (state == LOCKED) && (int'(grant) == i) && axis_o_tready;
        end
    end

    assign axis_o_tvalid = (state == LOCKED) && sel_valid;
    assign axis_o_tdata  = sel_data;
    assign axis_o_tuser  = sel_user;
    assign axis_o_tlast  = sel_last;
`ifdef AXIS_PACKET_ARBITER_TDEST_EN
    assign axis_o_tdest  = grant;
`endif

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_nxt = pick;
                    state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                if (sel_valid && axis_o_tready && sel_last) begin
                    state_nxt      = IDLE;
                    last_grant_nxt = grant;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= DB'(N - 1);
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
        end
    end

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed bench for axis_packet_arbiter with 4 inputs; per-input source queues
// feed the DUT and every output beat is matched against an expected queue.
module tb_axis_packet_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          aresetn;
    logic [N-1:0]  in_tvalid;
    logic [N-1:0]  in_tready;
    logic [N*8-1:0] in_tdata;
    logic [N-1:0]  in_tuser;
    logic [N-1:0]  in_tlast;
    logic          o_tvalid;
    logic          o_tready;
    logic [7:0]    o_tdata;
    logic [0:0]    o_tuser;
    logic          o_tlast;
`ifdef AXIS_PACKET_ARBITER_TDEST_EN
    logic [1:0]    o_tdest;
`endif

    axis_packet_arbiter #(
        .AXIS_BYTES        (1),
        .AXIS_USER_BITS    (1),
        .NUM_SLAVE_STREAMS (N)
    ) dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .axis_i_tvalid (in_tvalid),
        .axis_i_tready (in_tready),
        .axis_i_tdata  (in_tdata),
        .axis_i_tuser  (in_tuser),
        .axis_i_tlast  (in_tlast),
        .axis_o_tvalid (o_tvalid),
        .axis_o_tready (o_tready),
        .axis_o_tdata  (o_tdata),
        .axis_o_tuser  (o_tuser),
`ifdef AXIS_PACKET_ARBITER_TDEST_EN
        .axis_o_tdest  (o_tdest),
`endif
        .axis_o_tlast  (o_tlast)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // source beat {user, last, data}; expected beat {src[1:0], user, last, data}
    logic [9:0]  src_q [N][$];
    logic [11:0] exp_q [$];
    logic [N-1:0] hold;
    logic        tv_chk;
    logic        exp_v;
    logic        watch3;
    logic        in0_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive_srcs();
        logic [9:0] b;
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0 && !hold[i]) begin
                b = src_q[i][0];
                in_tvalid[i]       = 1'b1;
                in_tdata[i*8 +: 8] = b[7:0];
                in_tlast[i]        = b[8];
                in_tuser[i]        = b[9];
            end else begin
                in_tvalid[i] = 1'b0;
            end
        end
    endtask

    task automatic push_beat(input int src, input logic [7:0] d, input logic l, input logic add_exp);
        logic [1:0] s;
        s = src[1:0];
        src_q[src].push_back({d[0], l, d});
        if (add_exp) exp_q.push_back({s, d[0], l, d});
    endtask

    task automatic push_pkt(input int src, input int len, input logic [7:0] base);
        for (int b = 0; b < len; b++) push_beat(src, base + 8'(b), (b == len - 1), 1'b1);
    endtask

    // One clock: sample/score at the falling edge, then retire accepted source beats.
    task automatic cycle();
        logic [N-1:0] fire;
        logic [11:0]  exp;
        int           gidx;
        @(negedge clk);
        fire = in_tvalid & in_tready;
        if (tv_chk) check("o_tvalid_pattern", {31'd0, o_tvalid}, {31'd0, exp_v});
        if (o_tvalid && o_tready) begin
            gidx = -1;
            for (int i = 0; i < N; i++) if (in_tready[i]) gidx = i;
            check("beat_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                check("beat", {20'd0, gidx[1:0], o_tuser, o_tlast, o_tdata}, {20'd0, exp});
`ifdef AXIS_PACKET_ARBITER_TDEST_EN
                check("tdest", {30'd0, o_tdest}, {30'd0, gidx[1:0]});
`endif
            end
            if (o_tlast && gidx == 0) in0_done = 1'b1;
        end
        if (watch3 && !in0_done) check("in3_blocked", {31'd0, in_tready[3]}, 32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (fire[i]) void'(src_q[i].pop_front());
        drive_srcs();
    endtask

    task automatic drain(input string tag, input int bound);
        int n = 0;
        while (exp_q.size() > 0 && n < bound) begin
            cycle();
            n++;
        end
        check(tag, exp_q.size(), 32'd0);
        cycle();
        cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn   = 1'b0;
        in_tvalid = '0;
        in_tdata  = '0;
        in_tuser  = '0;
        in_tlast  = '0;
        o_tready  = 1'b1;
        hold      = '0;
        tv_chk    = 1'b0;
        exp_v     = 1'b0;
        watch3    = 1'b0;
        in0_done  = 1'b0;

        // reset state
        #12;
        check("rst_tvalid", {31'd0, o_tvalid}, 32'd0);
        check("rst_tready", {28'd0, in_tready}, 32'd0);
`ifdef AXIS_PACKET_ARBITER_TDEST_EN
        check("rst_tdest", {30'd0, o_tdest}, 32'd0);
`endif
        @(posedge clk);
        #1;
        aresetn = 1'b1;

        // idle for 10 cycles
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("idle_tvalid", {31'd0, o_tvalid}, 32'd0);
            check("idle_tready", {28'd0, in_tready}, 32'd0);
            @(posedge clk);
            #1;
        end

        // all four inputs offer 2-beat packets at once
        for (int i = 0; i < N; i++) push_pkt(i, 2, 8'(8'h10 * (i + 1) + 1));
        drive_srcs();
        tv_chk = 1'b1;
        for (int c = 0; c < 12; c++) begin
            exp_v = (c % 3) != 0;
            cycle();
        end
        tv_chk = 1'b0;
        check("rr4_done_in_12", exp_q.size(), 32'd0);
        cycle();

        // input 2 streams 1-beat packets, input 1 joins with one packet
        push_pkt(2, 1, 8'h20);
        drive_srcs();
        cycle();
        push_pkt(1, 1, 8'h40);
        push_pkt(2, 1, 8'h22);
        push_pkt(2, 1, 8'h24);
        push_pkt(2, 1, 8'h26);
        drive_srcs();
        drain("stream_drain", 40);

        // locked on input 0 with ready toggling and a tvalid gap; input 3 must wait
        in0_done = 1'b0;
        push_pkt(0, 4, 8'h60);
        drive_srcs();
        cycle();
        push_pkt(3, 2, 8'h70);
        watch3 = 1'b1;
        drive_srcs();
        for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
            o_tready = (c % 2) == 0;
            hold[0]  = (c == 3 || c == 4);
            drive_srcs();
            cycle();
        end
        o_tready = 1'b1;
        hold     = '0;
        watch3   = 1'b0;
        drive_srcs();
        check("toggle_in0_done", {31'd0, in0_done}, 32'd1);
        drain("toggle_drain", 20);

        // reset on beat 2 of a 4-beat packet from input 1
        push_pkt(1, 1, 8'h80);
        push_beat(1, 8'h81, 1'b0, 1'b1);
        push_beat(1, 8'h82, 1'b0, 1'b0);
        push_beat(1, 8'h83, 1'b0, 1'b0);
        push_beat(1, 8'h84, 1'b1, 1'b0);
        drive_srcs();
        for (int c = 0; c < 4; c++) cycle();
        check("pre_rst_beats_seen", exp_q.size(), 32'd0);
        check("pre_rst_tvalid", {31'd0, o_tvalid}, 32'd1);
        aresetn = 1'b0;
        #1;
        check("midrst_tvalid", {31'd0, o_tvalid}, 32'd0);
        check("midrst_tready", {28'd0, in_tready}, 32'd0);
        cycle();
        aresetn = 1'b1;
        src_q[1].delete();
        push_pkt(0, 1, 8'h91);
        push_pkt(2, 1, 8'hA1);
        drive_srcs();
        drain("post_rst_drain", 20);

        // input 3 packet 0xA5, 0x5A
        push_beat(3, 8'hA5, 1'b0, 1'b1);
        push_beat(3, 8'h5A, 1'b1, 1'b1);
        drive_srcs();
        drain("in3_drain", 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
